// File: rtl/pattern_merge_pipe.sv
// pattern_merge_pipe: elastic pipeline of STAGES pattern-merge stages.
// Each stage loads f(x) ^ q_s, where f is a fixed nor/nand neighbour mix and
// q_s is the word the stage last held. q_s is kept after the word drains, so it
// acts as history for the next load. A combinational ready chain gives one word
// per cycle. flush synchronously clears all stage state and blocks transfers.
// Optional: define PATTERN_MERGE_PERF_EN to add the out_count/stall_count
// performance counters.
module pattern_merge_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PATTERN_MERGE_PERF_EN
  ,
  output logic [31:0]      out_count,
  output logic [31:0]      stall_count
`endif
);

  // Neighbour mix: even bits nor with the next bit, odd bits nand with it.
  function automatic logic [WIDTH-1:0] mix(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      int j;
      j = (i + 1) % int'(WIDTH);
      if ((i % 2) == 0) r[i] = ~(x[i] | x[j]);
      else              r[i] = ~(x[i] & x[j]);
    end
    return r;
  endfunction

  logic [WIDTH-1:0]  q_q [STAGES];
  logic [WIDTH-1:0]  q_d [STAGES];
  logic [WIDTH-1:0]  din [STAGES+1];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] acc;
  logic [STAGES:0]   acc_ext;
  logic [STAGES:0]   up_valid;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] leave;

  // Stage s accepts if any stage from s to the end is empty, or out_ready.
  // This is the unrolled ready chain, computed without a self-referencing net.
  always_comb begin
    acc = '0;
    for (int s = 0; s < int'(STAGES); s++) begin
      acc[s] = out_ready;
      for (int t = s; t < int'(STAGES); t++) begin
        if (!v_q[t]) acc[s] = 1'b1;
      end
    end
  end

  // Per-stage load/leave decisions and next-state data.
  always_comb begin
    acc_ext  = {out_ready, acc};
    up_valid = {v_q, in_valid};
    din[0]   = in_data;
    for (int s = 0; s < int'(STAGES); s++) din[s+1] = q_q[s];
    load  = '0;
    leave = '0;
    v_d   = v_q;
    for (int s = 0; s < int'(STAGES); s++) begin
      q_d[s]   = q_q[s];
      load[s]  = up_valid[s] & acc[s] & ~flush;
      leave[s] = v_q[s] & acc_ext[s+1] & ~flush;
      if (flush) begin
        v_d[s] = 1'b0;
        q_d[s] = '0;
      end else if (load[s]) begin
        v_d[s] = 1'b1;
        q_d[s] = mix(din[s]) ^ q_q[s];
      end else if (leave[s]) begin
        v_d[s] = 1'b0;
      end
    end
  end

  // Stage registers.
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      v_q <= '0;
      for (int s = 0; s < int'(STAGES); s++) q_q[s] <= '0;
    end else begin
      v_q <= v_d;
      for (int s = 0; s < int'(STAGES); s++) q_q[s] <= q_d[s];
    end
  end

  // Handshake outputs.
  always_comb begin
    in_ready  = acc[0] & ~flush;
    out_valid = v_q[STAGES-1];
    out_data  = q_q[STAGES-1];
  end

`ifdef PATTERN_MERGE_PERF_EN
  logic [31:0] out_count_q;
  logic [31:0] stall_count_q;

  // Transfer and stall counters; they wrap naturally and flush clears them.
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      out_count_q   <= '0;
      stall_count_q <= '0;
    end else if (flush) begin
      out_count_q   <= '0;
      stall_count_q <= '0;
    end else begin
      if (out_valid && out_ready)  out_count_q   <= out_count_q + 32'd1;
      if (out_valid && !out_ready) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  always_comb begin
    out_count   = out_count_q;
    stall_count = stall_count_q;
  end
`endif

endmodule

// File: tb/tb_pattern_merge_pipe.sv
// Self-checking bench for pattern_merge_pipe (WIDTH=4, STAGES=2).
// A reference model computes each word's output when it is accepted and pushes
// it to a scoreboard queue; outputs are popped and compared on transfer.
module tb_pattern_merge_pipe;
  localparam int W  = 4;
  localparam int ST = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
`ifdef PATTERN_MERGE_PERF_EN
  logic [31:0]  out_count;
  logic [31:0]  stall_count;
`endif

  pattern_merge_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .blif_clk_net  (clk),
    .blif_reset_net(rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
`ifdef PATTERN_MERGE_PERF_EN
    ,
    .out_count     (out_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [W-1:0] sbq[$];
  logic [W-1:0] hist [ST];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_mix(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      if (i % 2 == 0) r[i] = ~(x[i] | x[(i + 1) % W]);
      else            r[i] = ~(x[i] & x[(i + 1) % W]);
    end
    return r;
  endfunction

  // Scoreboard monitor: handshakes are decided by the inputs stable at negedge.
  always @(negedge clk) begin
    if (rst || flush) begin
      sbq.delete();
      for (int s = 0; s < ST; s++) hist[s] = '0;
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        if (sbq.size() == 0) begin
          check("unexpected_output", 32'(out_data), 32'hDEAD);
        end else begin
          check("data", 32'(out_data), 32'(sbq.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        logic [W-1:0] x;
        x = in_data;
        for (int s = 0; s < ST; s++) begin
          hist[s] = ref_mix(x) ^ hist[s];
          x = hist[s];
        end
        sbq.push_back(x);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic iv;
    logic ordy;
    logic fl;
    logic exp_ir;
    logic exp_ov;
  } ctl_t;

  ctl_t tbl [8];

  initial begin
    int n;
    int gaps;
    int irdrop;
    int p0;
    logic [W-1:0] held;
    logic have_held;

    // Control vectors from an empty pipe: {in_valid, out_ready, flush, in_ready, out_valid}.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    #2;
    do_reset();
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", 32'(out_data), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    step();

    // History chain: two zero words give 0 then F.
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 4'h0;
    step();
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("chain_first_valid", 32'(out_valid), 32'd1);
    check("chain_first_data", 32'(out_data), 32'h0);
    step();
    @(negedge clk);
    check("chain_second_valid", 32'(out_valid), 32'd1);
    check("chain_second_data", 32'(out_data), 32'hF);
    step();

    // Table-driven control sequence.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in_valid = tbl[k].iv;
      out_ready = tbl[k].ordy;
      flush = tbl[k].fl;
      in_data = W'($urandom);
      @(negedge clk);
      check($sformatf("tbl%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].exp_ir));
      check($sformatf("tbl%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].exp_ov));
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;

    // Full throughput: 20 back-to-back words.
    do_reset();
    out_ready = 1'b1;
    gaps = 0;
    irdrop = 0;
    p0 = pops;
    for (int k = 0; k < 23; k++) begin
      in_valid = (k < 20);
      in_data = W'($urandom);
      @(negedge clk);
      if (k < 20 && !in_ready) irdrop++;
      if (out_valid !== ((k >= 2) && (k < 22))) gaps++;
      step();
    end
    in_valid = 1'b0;
    check("thru_in_ready_drops", 32'(irdrop), 32'd0);
    check("thru_out_valid_gaps", 32'(gaps), 32'd0);
    check("thru_outputs", 32'(pops - p0), 32'd20);

    // Backpressure: only STAGES words enter, output holds steady.
    out_ready = 1'b0;
    n = 0;
    gaps = 0;
    have_held = 1'b0;
    held = '0;
    p0 = pops;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      in_data = W'($urandom);
      @(negedge clk);
      if (in_ready) n++;
      if (out_valid) begin
        if (have_held && out_data !== held) gaps++;
        held = out_data;
        have_held = 1'b1;
      end
      step();
    end
    @(negedge clk);
    check("bp_accepted", 32'(n), 32'd2);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_data_stable", 32'(gaps), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sbq.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("bp_drained", 32'(pops - p0), 32'd2);
    check("bp_queue_empty", 32'(sbq.size()), 32'd0);
    step();

    // Flush with the pipe full clears valid and history.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = W'($urandom);
    step();
    in_data = W'($urandom);
    step();
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready_after", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 4'h0;
    step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    check("flush_zero_valid", 32'(out_valid), 32'd1);
    check("flush_zero_data", 32'(out_data), 32'h0);
    step();

    // Asynchronous reset between edges mid-burst.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = W'($urandom);
      step();
    end
    #2;
    rst = 1'b1;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_out_data", 32'(out_data), 32'd0);
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    p0 = pops;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = W'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    step();
    check("areset_resume_outputs", 32'(pops - p0), 32'd5);
    check("areset_queue_empty", 32'(sbq.size()), 32'd0);

`ifdef PATTERN_MERGE_PERF_EN
    // Five transfers and three stall cycles.
    do_reset();
    for (int k = 0; k < 13; k++) begin
      in_valid = (k < 5);
      out_ready = !(k >= 5 && k < 8);
      in_data = W'($urandom);
      step();
    end
    @(negedge clk);
    check("perf_out_count", out_count, 32'd5);
    check("perf_stall_count", stall_count, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
